dram_req_arbiter: RTL and testbench

Shares the DRAM controller among NUM_REQ requesters. Round-robin arbitration picks one requester, latches its bank/row/col and presents them to the controller's address path with a one-cycle `addr_val`. The grant is held until the controller signals access completion. A built-in refresh timer raises `refresh_flag` periodically and blocks new grants until the refresh is acknowledged.

---
 rtl/dram_pkg.sv | 24 ++
 rtl/dram_req_arbiter_refresh.sv | 51 +++++
 rtl/dram_req_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_dram_req_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM request arbiter and controller FSM.
// Contents:
//   arb_state_e  : arbiter state encoding (IDLE, BUSY, REFRESH)
//   ARB_STATE_W  : width of the state encoding
//   dram_idx_w() : index width for a count of items; never less than 1
package dram_pkg;

    localparam int ARB_STATE_W = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        REFRESH = 2'b10
    } arb_state_e;

    function automatic int dram_idx_w(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/dram_req_arbiter_refresh.sv
// dram_refresh_timer: periodic refresh request generator.
// A down-counter reloads at zero and raises refresh_flag. The flag is cleared
// by refresh_done. An expiry that finds the flag still pending, with no
// refresh_done in that cycle, sets the sticky refresh_miss.
// Ports:
//   clk, rst_b    : clock and asynchronous active-high reset
//   refresh_done  : controller pulse, refresh completed
//   refresh_flag  : refresh pending (registered)
//   refresh_miss  : sticky overrun indicator (registered)
module dram_refresh_timer #(
    parameter int REFRESH_INTERVAL = 1024
) (
    input  logic clk,
    input  logic rst_b,
    input  logic refresh_done,
    output logic refresh_flag,
    output logic refresh_miss
);
    import dram_pkg::*;

    localparam int TW = dram_idx_w(REFRESH_INTERVAL);
    localparam logic [TW-1:0] RELOAD = TW'(REFRESH_INTERVAL - 1);

    logic [TW-1:0] count_r;
    logic          expire_s;

    assign expire_s = (count_r == {TW{1'b0}});

    // Counter, pending flag and sticky miss; expiry beats a coincident refresh_done.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            count_r      <= RELOAD;
            refresh_flag <= 1'b0;
            refresh_miss <= 1'b0;
        end else begin
            if (expire_s) begin
                count_r      <= RELOAD;
                refresh_flag <= 1'b1;
                if (refresh_flag && !refresh_done) begin
                    refresh_miss <= 1'b1;
                end
            end else begin
                count_r <= count_r - TW'(1);
                if (refresh_done) begin
                    refresh_flag <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: round-robin arbiter sharing one DRAM controller among
// NUM_REQ requesters, with a built-in refresh timer that blocks new grants.
// Optional feature macro: DRAM_ARB_ROW_HIT_EN (open-row preference, capped
// at ROW_HIT_MAX consecutive hit grants).
// Ports:
//   clk, rst_b                  : clock, asynchronous active-high reset
//   req                         : per-requester request
//   req_bank/req_row/req_col    : packed addresses, requester i at [i*W +: W]
//   acc_done, refresh_done      : controller completion pulses
//   gnt                         : one-hot registered grant
//   addr_val                    : one-cycle pulse with a new address
//   bank_id/row_id/col_id       : latched address of the granted requester
//   refresh_flag, refresh_miss  : refresh pending / sticky overrun
module dram_req_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int NUMBER_OF_BANKS  = 8,
    parameter int NUMBER_OF_ROWS   = 128,
    parameter int NUMBER_OF_COLS   = 8,
    parameter int REFRESH_INTERVAL = 1024,
    parameter int ROW_HIT_MAX      = 4,
    localparam int BW = $clog2(NUMBER_OF_BANKS),
    localparam int RW = $clog2(NUMBER_OF_ROWS),
    localparam int CW = $clog2(NUMBER_OF_COLS)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*BW-1:0] req_bank,
    input  logic [NUM_REQ*RW-1:0] req_row,
    input  logic [NUM_REQ*CW-1:0] req_col,
    input  logic                  acc_done,
    input  logic                  refresh_done,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  addr_val,
    output logic [BW-1:0]         bank_id,
    output logic [RW-1:0]         row_id,
    output logic [CW-1:0]         col_id,
    output logic                  refresh_flag,
    output logic                  refresh_miss
);
    import dram_pkg::*;

    localparam int PW = dram_idx_w(NUM_REQ);

    arb_state_e           state_r, state_s;
    logic [PW-1:0]        ptr_r, ptr_s, win_r, win_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic                 addr_val_s;
    logic [BW-1:0]        bank_s;
    logic [RW-1:0]        row_s;
    logic [CW-1:0]        col_s;
    logic                 rr_found_s;
    logic [PW-1:0]        rr_win_s, sel_s;
    logic                 grant_s, ptr_adv_s;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        if (i == PW'(NUM_REQ - 1)) begin
            return {PW{1'b0}};
        end else begin
            return i + PW'(1);
        end
    endfunction

    dram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_timer (
        .clk          (clk),
        .rst_b        (rst_b),
        .refresh_done (refresh_done),
        .refresh_flag (refresh_flag),
        .refresh_miss (refresh_miss)
    );

    // Round-robin search; scanning downward lets the lowest offset from ptr win.
    always_comb begin
        logic [PW:0] idx_v;
        rr_found_s = 1'b0;
        rr_win_s   = {PW{1'b0}};
        idx_v      = {(PW+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_v = {1'b0, ptr_r} + (PW+1)'(k);
            idx_v = (idx_v >= (PW+1)'(NUM_REQ)) ? idx_v - (PW+1)'(NUM_REQ) : idx_v;
            if (req[idx_v[PW-1:0]]) begin
                rr_found_s = 1'b1;
                rr_win_s   = idx_v[PW-1:0];
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    assign grant_s = (state_r == IDLE) && !refresh_flag && rr_found_s;

`ifdef DRAM_ARB_ROW_HIT_EN
    localparam int CNTW = $clog2(ROW_HIT_MAX + 1);

    logic [NUM_REQ-1:0] hit_s;
    logic [PW-1:0]      hit_low_s;
    logic [CNTW-1:0]    hit_cnt_r, hit_cnt_s;
    logic               open_vld_r, adv_r, adv_s, force_rr_s;

    // Requesters targeting the currently open bank/row; lowest index recorded.
    always_comb begin
        hit_s     = {NUM_REQ{1'b0}};
        hit_low_s = {PW{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && open_vld_r && (req_bank[i*BW +: BW] == bank_id) &&
                (req_row[i*RW +: RW] == row_id)) begin
                hit_s[i]  = 1'b1;
                hit_low_s = PW'(i);
            end else begin
                hit_s[i]  = 1'b0;
            end
        end
    end

    // A hit only overrides round-robin when the rr winner is not itself a hit;
    // only an rr-chosen grant advances the pointer on completion.
    always_comb begin
        force_rr_s = (hit_cnt_r == CNTW'(ROW_HIT_MAX));
        if (!force_rr_s && (|hit_s) && !hit_s[rr_win_s]) begin
            sel_s = hit_low_s;
            adv_s = 1'b0;
        end else begin
            sel_s = rr_win_s;
            adv_s = 1'b1;
        end
        if (force_rr_s) begin
            hit_cnt_s = {CNTW{1'b0}};
        end else if (hit_s[sel_s]) begin
            hit_cnt_s = hit_cnt_r + CNTW'(1);
        end else begin
            hit_cnt_s = {CNTW{1'b0}};
        end
    end

    // Open-row tracking state, updated on each grant.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            hit_cnt_r  <= {CNTW{1'b0}};
            open_vld_r <= 1'b0;
            adv_r      <= 1'b1;
        end else if (grant_s) begin
            hit_cnt_r  <= hit_cnt_s;
            open_vld_r <= 1'b1;
            adv_r      <= adv_s;
        end
    end

    assign ptr_adv_s = adv_r;
`else
    assign sel_s     = rr_win_s;
    assign ptr_adv_s = 1'b1;
`endif

    // Next-state and next-output logic of the arbiter FSM.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        win_s      = win_r;
        gnt_s      = gnt;
        addr_val_s = 1'b0;
        bank_s     = bank_id;
        row_s      = row_id;
        col_s      = col_id;
        case (state_r)
            IDLE: begin
                if (refresh_flag) begin
                    state_s = REFRESH;
                end else if (rr_found_s) begin
                    state_s    = BUSY;
                    win_s      = sel_s;
                    gnt_s      = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_s;
                    addr_val_s = 1'b1;
                    bank_s     = req_bank[sel_s*BW +: BW];
                    row_s      = req_row[sel_s*RW +: RW];
                    col_s      = req_col[sel_s*CW +: CW];
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (acc_done) begin
                    state_s = IDLE;
                    gnt_s   = {NUM_REQ{1'b0}};
                    ptr_s   = ptr_adv_s ? next_idx(win_r) : ptr_r;
                end else begin
                    state_s = BUSY;
                end
            end
            REFRESH: begin
                if (refresh_done) begin
                    state_s = IDLE;
                end else begin
                    state_s = REFRESH;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_r  <= IDLE;
            ptr_r    <= {PW{1'b0}};
            win_r    <= {PW{1'b0}};
            gnt      <= {NUM_REQ{1'b0}};
            addr_val <= 1'b0;
            bank_id  <= {BW{1'b0}};
            row_id   <= {RW{1'b0}};
            col_id   <= {CW{1'b0}};
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            win_r    <= win_s;
            gnt      <= gnt_s;
            addr_val <= addr_val_s;
            bank_id  <= bank_s;
            row_id   <= row_s;
            col_id   <= col_s;
        end
    end

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Testbench for dram_req_arbiter: directed scenarios with fixed expectations
// plus a randomized run against a behavioural model of the arbitration rules.
module tb_dram_req_arbiter;
    localparam int N   = 4;
    localparam int BW  = 3;
    localparam int RW  = 7;
    localparam int CW  = 3;
    localparam int RI  = 16;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*BW-1:0] req_bank = '0;
    logic [N*RW-1:0] req_row = '0;
    logic [N*CW-1:0] req_col = '0;
    logic            acc_done = 1'b0;
    logic            refresh_done = 1'b0;
    logic [N-1:0]    gnt;
    logic            addr_val;
    logic [BW-1:0]   bank_id;
    logic [RW-1:0]   row_id;
    logic [CW-1:0]   col_id;
    logic            refresh_flag;
    logic            refresh_miss;

    int n_checks = 0;
    int n_fail   = 0;

    dram_req_arbiter #(
        .NUM_REQ(N), .NUMBER_OF_BANKS(8), .NUMBER_OF_ROWS(128), .NUMBER_OF_COLS(8),
        .REFRESH_INTERVAL(RI), .ROW_HIT_MAX(2)
    ) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .req_bank(req_bank), .req_row(req_row),
        .req_col(req_col), .acc_done(acc_done), .refresh_done(refresh_done),
        .gnt(gnt), .addr_val(addr_val), .bank_id(bank_id), .row_id(row_id),
        .col_id(col_id), .refresh_flag(refresh_flag), .refresh_miss(refresh_miss)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b1; req = '0; acc_done = 1'b0; refresh_done = 1'b0;
        step(2);
        rst_b = 1'b0;
    endtask

    task automatic set_addr(input int i, input int b, input int r, input int c);
        req_bank[i*BW +: BW] = BW'(b);
        req_row[i*RW +: RW]  = RW'(r);
        req_col[i*CW +: CW]  = CW'(c);
    endtask

    task automatic default_addrs();
        for (int i = 0; i < N; i++) set_addr(i, i, 10 + i, 7 - i);
    endtask

    task automatic pulse_acc();
        acc_done = 1'b1; step(1); acc_done = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        n_checks++;
        if ({gnt, addr_val, bank_id, row_id, col_id, refresh_flag, refresh_miss} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b av=%b b=%0d r=%0d c=%0d flag=%b miss=%b, required all 0",
                     gnt, addr_val, bank_id, row_id, col_id, refresh_flag, refresh_miss);
        end
        step(1);
        rst_b = 1'b0;
    endtask

    task automatic test_rr_wrap();
        do_reset();
        default_addrs();
        req = 4'b0101;
        step(1);
        n_checks++;
        if (gnt !== 4'b0001 || addr_val !== 1'b1 || bank_id !== 3'd0 || row_id !== 7'd10 || col_id !== 3'd7) begin
            n_fail++;
            $display("FAIL rr_first: gnt=%b av=%b b=%0d r=%0d c=%0d, required 0001 1 0 10 7",
                     gnt, addr_val, bank_id, row_id, col_id);
        end
        step(1);
        n_checks++;
        if (gnt !== 4'b0001 || addr_val !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_hold: gnt=%b av=%b, required 0001 0", gnt, addr_val);
        end
        pulse_acc();
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_release: gnt=%b, required 0000", gnt);
        end
        step(1);
        n_checks++;
        if (gnt !== 4'b0100 || addr_val !== 1'b1 || bank_id !== 3'd2 || row_id !== 7'd12 || col_id !== 3'd5) begin
            n_fail++;
            $display("FAIL rr_second: gnt=%b av=%b b=%0d r=%0d c=%0d, required 0100 1 2 12 5",
                     gnt, addr_val, bank_id, row_id, col_id);
        end
        pulse_acc();
        step(1);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_wrap: gnt=%b, required 0001", gnt);
        end
        pulse_acc();
        req = '0;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_g;
        do_reset();
        default_addrs();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step(1);
            exp_g = N'(1) << (k % N);
            n_checks++;
            if (gnt !== exp_g || addr_val !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_grant%0d: gnt=%b av=%b, required %b 1", k, gnt, addr_val, exp_g);
            end
            pulse_acc();
            n_checks++;
            if (gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL b2b_bubble%0d: gnt=%b, required 0000", k, gnt);
            end
        end
        req = '0;
    endtask

    task automatic test_refresh_timer();
        do_reset();
        step(RI - 1);
        n_checks++;
        if (refresh_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL timer_early: flag=%b, required 0", refresh_flag);
        end
        step(1);
        n_checks++;
        if (refresh_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL timer_first: flag=%b, required 1", refresh_flag);
        end
        refresh_done = 1'b1; step(1); refresh_done = 1'b0;
        n_checks++;
        if (refresh_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL timer_clear: flag=%b, required 0", refresh_flag);
        end
        step(RI - 2);
        n_checks++;
        if (refresh_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL timer_second_early: flag=%b, required 0", refresh_flag);
        end
        step(1);
        n_checks++;
        if (refresh_flag !== 1'b1 || refresh_miss !== 1'b0) begin
            n_fail++;
            $display("FAIL timer_second: flag=%b miss=%b, required 1 0", refresh_flag, refresh_miss);
        end
        refresh_done = 1'b1; step(1); refresh_done = 1'b0;
    endtask

    task automatic test_refresh_blocks();
        do_reset();
        default_addrs();
        step(RI);
        req = 4'b0010;
        step(2);
        n_checks++;
        if (gnt !== 4'b0000 || refresh_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL refresh_block: gnt=%b flag=%b, required 0000 1", gnt, refresh_flag);
        end
        refresh_done = 1'b1; step(1); refresh_done = 1'b0;
        n_checks++;
        if (gnt !== 4'b0000 || refresh_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL refresh_done_cycle: gnt=%b flag=%b, required 0000 0", gnt, refresh_flag);
        end
        step(1);
        n_checks++;
        if (gnt !== 4'b0010 || addr_val !== 1'b1 || bank_id !== 3'd1) begin
            n_fail++;
            $display("FAIL refresh_then_grant: gnt=%b av=%b b=%0d, required 0010 1 1", gnt, addr_val, bank_id);
        end
        pulse_acc();
        req = '0;
    endtask

    task automatic test_refresh_miss();
        do_reset();
        default_addrs();
        step(2 * RI - 1);
        n_checks++;
        if (refresh_miss !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_early: miss=%b, required 0", refresh_miss);
        end
        step(1);
        n_checks++;
        if (refresh_miss !== 1'b1 || refresh_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_set: miss=%b flag=%b, required 1 1", refresh_miss, refresh_flag);
        end
        refresh_done = 1'b1; step(1); refresh_done = 1'b0;
        n_checks++;
        if (refresh_miss !== 1'b1 || refresh_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_sticky: miss=%b flag=%b, required 1 0", refresh_miss, refresh_flag);
        end
        req = 4'b0001;
        step(1);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL miss_grant: gnt=%b, required 0001", gnt);
        end
        step(1);
        #2 rst_b = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || refresh_miss !== 1'b0 || refresh_flag !== 1'b0 || addr_val !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: gnt=%b miss=%b flag=%b av=%b, required 0000 0 0 0",
                     gnt, refresh_miss, refresh_flag, addr_val);
        end
        req = '0;
        step(1);
        rst_b = 1'b0;
    endtask

`ifdef DRAM_ARB_ROW_HIT_EN
    task automatic test_row_hit();
        int order [4];
        order = '{0, 1, 0, 2};
        do_reset();
        set_addr(0, 5, 33, 1);
        set_addr(1, 5, 33, 2);
        set_addr(2, 1, 2, 3);
        set_addr(3, 2, 3, 4);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step(1);
            n_checks++;
            if (gnt !== (N'(1) << order[k])) begin
                n_fail++;
                $display("FAIL row_hit%0d: gnt=%b, required requester %0d", k, gnt, order[k]);
            end
            pulse_acc();
        end
        req = '0;
    endtask
`endif

    // Randomized run; the model tracks what the arbiter is doing and which
    // requester holds the grant, recomputed from the arbitration rules.
    task automatic test_random(input int cycles);
        int m_timer, m_mode, m_owner, m_ptr, found, idx, shown;
        bit m_flag, m_miss, m_av, n_flag, n_miss, expired;
        logic [BW-1:0] m_bank;
        logic [RW-1:0] m_row;
        logic [CW-1:0] m_col;
        logic [N-1:0]  exp_g;
        shown = 0;
        for (int c = 0; c < cycles; c++) begin
            if (c == 0 || c == cycles / 2) begin
                do_reset();
                m_timer = RI - 1; m_mode = 0; m_owner = -1; m_ptr = 0;
                m_flag = 0; m_miss = 0; m_av = 0; m_bank = '0; m_row = '0; m_col = '0;
            end
            req          = N'($urandom);
            req_bank     = (N*BW)'($urandom);
            req_row      = (N*RW)'($urandom);
            req_col      = (N*CW)'($urandom);
            acc_done     = ($urandom_range(0, 2) == 0);
            refresh_done = ($urandom_range(0, 7) == 0);
            expired = (m_timer == 0);
            n_flag  = m_flag;
            n_miss  = m_miss;
            if (expired) begin
                n_flag = 1;
                if (m_flag && !refresh_done) n_miss = 1;
            end else if (refresh_done) begin
                n_flag = 0;
            end
            m_timer = expired ? RI - 1 : m_timer - 1;
            m_av = 0;
            if (m_mode == 0) begin
                if (m_flag) begin
                    m_mode = 2;
                end else if (req != 0) begin
                    found = -1;
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (found < 0 && req[idx]) found = idx;
                    end
                    m_owner = found;
                    m_bank  = req_bank[found*BW +: BW];
                    m_row   = req_row[found*RW +: RW];
                    m_col   = req_col[found*CW +: CW];
                    m_av    = 1;
                    m_mode  = 1;
                end
            end else if (m_mode == 1) begin
                if (acc_done) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_mode  = 0;
                end
            end else begin
                if (refresh_done) m_mode = 0;
            end
            m_flag = n_flag;
            m_miss = n_miss;
            step(1);
            exp_g = (m_owner < 0) ? '0 : (N'(1) << m_owner);
            n_checks++;
            if (gnt !== exp_g || addr_val !== m_av || bank_id !== m_bank || row_id !== m_row ||
                col_id !== m_col || refresh_flag !== m_flag || refresh_miss !== m_miss) begin
                n_fail++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_c%0d: got gnt=%b av=%b b=%0d r=%0d c=%0d f=%b m=%b, required gnt=%b av=%b b=%0d r=%0d c=%0d f=%b m=%b",
                             c, gnt, addr_val, bank_id, row_id, col_id, refresh_flag, refresh_miss,
                             exp_g, m_av, m_bank, m_row, m_col, m_flag, m_miss);
                end
            end
        end
        req = '0; acc_done = 1'b0; refresh_done = 1'b0;
    endtask

    initial begin
        rst_b = 1'b1;
        step(2);
        rst_b = 1'b0;
        test_reset();
        test_rr_wrap();
        test_back_to_back();
        test_refresh_timer();
        test_refresh_blocks();
        test_refresh_miss();
`ifdef DRAM_ARB_ROW_HIT_EN
        test_row_hit();
`else
        test_random(3000);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
